// File: rtl/rv_mem_pkg.sv
// Shared constants for the data-memory load/store path: funct3 codes, memory
// direction and size selects, LSU state encoding, and access-legality helpers.
package rv_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

    localparam logic [1:0] SEL_WORD_IN  = 2'b00;
    localparam logic [2:0] SEL_WORD_OUT = 3'b000;

    localparam logic [1:0] LSU_IDLE  = 2'd0;
    localparam logic [1:0] LSU_READ  = 2'd1;
    localparam logic [1:0] LSU_WRITE = 2'd2;
    localparam logic [1:0] LSU_RESP  = 2'd3;

    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we)
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    // Size lives in funct3[1:0]; illegal codes are faulted elsewhere.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b01:   return off[0];
            2'b10:   return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_unit.sv
// Byte-lane unit: extracts and sign/zero-extends a load from a memory word, and
// merges sub-word store data into a word. Purely combinational.
module lsu_lane_unit
    import rv_mem_pkg::*;
#(
    parameter int DATA_SIZE = 32
) (
    input  logic [DATA_SIZE-1:0] i_word,
    input  logic [DATA_SIZE-1:0] i_wdata,
    input  logic [1:0]           i_offset,
    input  logic [2:0]           i_funct3,
    output logic [DATA_SIZE-1:0] o_merged,
    output logic [DATA_SIZE-1:0] o_loaded
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_word[{i_offset, 3'b000} +: 8];
        w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];

        case (i_funct3)
            F3_B:    o_loaded = {{(DATA_SIZE-8){w_byte[7]}}, w_byte};
            F3_BU:   o_loaded = {{(DATA_SIZE-8){1'b0}}, w_byte};
            F3_H:    o_loaded = {{(DATA_SIZE-16){w_half[15]}}, w_half};
            F3_HU:   o_loaded = {{(DATA_SIZE-16){1'b0}}, w_half};
            default: o_loaded = i_word;
        endcase

        o_merged = i_word;
        case (i_funct3[1:0])
            2'b00:   o_merged[{i_offset, 3'b000} +: 8]  = i_wdata[7:0];
            2'b01:   o_merged[{i_offset[1], 4'b0000} +: 16] = i_wdata[15:0];
            default: o_merged = i_wdata;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// RV32I load/store unit driving a word-indexed data memory; one request per handshake,
// response after 1 (fault), 2 (load/SW) or 3 (SB/SH read-modify-write) cycles; req_ready only in IDLE.
module dmem_lsu
    import rv_mem_pkg::*;
#(
    parameter int DATA_SIZE      = 32,
    parameter int ADDRESS_SIZE   = 32,
    parameter int WORD_ADDR_BITS = 18
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [2:0]              req_funct3,
    input  logic [ADDRESS_SIZE-1:0] req_addr,
    input  logic [DATA_SIZE-1:0]    req_wdata,
    output logic                    resp_valid,
    output logic [DATA_SIZE-1:0]    resp_rdata,
    output logic                    resp_err,
    output logic                    mem_rw,
    output logic [ADDRESS_SIZE-1:0] mem_addr,
    output logic [1:0]              mem_data_in_sel,
    output logic [2:0]              mem_data_out_sel,
    output logic [DATA_SIZE-1:0]    mem_wdata,
    input  logic [DATA_SIZE-1:0]    mem_rdata
);

    logic [1:0]                r_state;
    logic                      r_we;
    logic [2:0]                r_funct3;
    logic [WORD_ADDR_BITS+1:0] r_addr;
    logic [DATA_SIZE-1:0]      r_wdata;
    logic [DATA_SIZE-1:0]      r_rd;
    logic [DATA_SIZE-1:0]      r_resp_rdata;
    logic                      r_resp_err;

    logic                      w_accept;
    logic                      w_oor;
    logic                      w_fault;
    logic [DATA_SIZE-1:0]      w_lane_word;
    logic [DATA_SIZE-1:0]      w_merged;
    logic [DATA_SIZE-1:0]      w_loaded;

    assign req_ready = (r_state == LSU_IDLE) && !rst;
    assign w_accept  = req_valid && req_ready;

    // Legality is decided from the request as it is registered, so the IDLE
    // transition can go straight to RESP on a fault.
    assign w_oor   = |req_addr[ADDRESS_SIZE-1:WORD_ADDR_BITS+2];
    assign w_fault = !f3_legal(req_we, req_funct3) ||
                     misaligned(req_funct3, req_addr[1:0]) || w_oor;

    // READ extracts from the live memory word; WRITE merges into the captured one.
    assign w_lane_word = (r_state == LSU_WRITE) ? r_rd : mem_rdata;

    lsu_lane_unit #(
        .DATA_SIZE (DATA_SIZE)
    ) u_lane (
        .i_word   (w_lane_word),
        .i_wdata  (r_wdata),
        .i_offset (r_addr[1:0]),
        .i_funct3 (r_funct3),
        .o_merged (w_merged),
        .o_loaded (w_loaded)
    );

    assign resp_valid       = (r_state == LSU_RESP);
    assign resp_rdata       = r_resp_rdata;
    assign resp_err         = r_resp_err;
    assign mem_rw           = (r_state == LSU_WRITE) ? MEM_WRITE : MEM_READ;
    assign mem_addr         = {{(ADDRESS_SIZE-WORD_ADDR_BITS){1'b0}}, r_addr[WORD_ADDR_BITS+1:2]};
    assign mem_data_in_sel  = SEL_WORD_IN;
    assign mem_data_out_sel = SEL_WORD_OUT;
    assign mem_wdata        = (r_state == LSU_WRITE) ? w_merged : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= LSU_IDLE;
            r_we         <= 1'b0;
            r_funct3     <= 3'b000;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rd         <= '0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            case (r_state)
                LSU_IDLE: begin
                    if (w_accept) begin
                        r_we       <= req_we;
                        r_funct3   <= req_funct3;
                        r_addr     <= req_addr[WORD_ADDR_BITS+1:0];
                        r_wdata    <= req_wdata;
                        r_resp_err <= w_fault;
                        if (w_fault)
                            r_state <= LSU_RESP;
                        else if (req_we && (req_funct3 == F3_W))
                            r_state <= LSU_WRITE;
                        else
                            r_state <= LSU_READ;
                    end
                end
                LSU_READ: begin
                    r_rd <= mem_rdata;
                    if (r_we) begin
                        r_state <= LSU_WRITE;
                    end else begin
                        r_resp_rdata <= w_loaded;
                        r_state      <= LSU_RESP;
                    end
                end
                LSU_WRITE: r_state <= LSU_RESP;
                LSU_RESP: begin
                    r_resp_rdata <= '0;
                    r_resp_err   <= 1'b0;
                    r_state      <= LSU_IDLE;
                end
                default: r_state <= LSU_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a word-indexed memory model and hand-computed expectations.
module tb_dmem_lsu;
    import rv_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_rw;
    logic [31:0] mem_addr;
    logic [1:0]  mem_data_in_sel;
    logic [2:0]  mem_data_out_sel;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    dmem_lsu dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_we           (req_we),
        .req_funct3       (req_funct3),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .resp_valid       (resp_valid),
        .resp_rdata       (resp_rdata),
        .resp_err         (resp_err),
        .mem_rw           (mem_rw),
        .mem_addr         (mem_addr),
        .mem_data_in_sel  (mem_data_in_sel),
        .mem_data_out_sel (mem_data_out_sel),
        .mem_wdata        (mem_wdata),
        .mem_rdata        (mem_rdata)
    );

    logic [31:0] mem [0:1023];
    logic        pl_en = 1'b0;
    logic [9:0]  pl_idx = '0;
    logic [31:0] pl_dat = '0;
    int          wr_cnt = 0;

    assign mem_rdata = mem[mem_addr[9:0]];

    always @(posedge clk) begin
        if (mem_rw) begin
            mem[mem_addr[9:0]] <= mem_wdata;
            wr_cnt <= wr_cnt + 1;
        end else if (pl_en) begin
            mem[pl_idx] <= pl_dat;
        end
    end

    int n_tot = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic preload(input int idx, input logic [31:0] d);
        pl_en  = 1'b1;
        pl_idx = idx[9:0];
        pl_dat = d;
        @(negedge clk);
        pl_en  = 1'b0;
    endtask

    // Starts and ends on a negedge with the LSU in IDLE, so calls chain back-to-back.
    task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output logic err,
                        output int lat, output int nwr, output int nrdy);
        rd = '0; err = 1'b0; lat = 0; nwr = 0; nrdy = 0;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        check("ready_before_req", 32'(req_ready), 32'd1);
        @(posedge clk);
        for (int c = 1; c <= 8 && lat == 0; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (mem_rw) nwr++;
            if (req_ready) nrdy++;
            if (resp_valid) begin
                lat = c;
                rd  = resp_rdata;
                err = resp_err;
            end
        end
        @(negedge clk);
        check("resp_one_cycle", 32'(resp_valid), 32'd0);
        check("ready_after_resp", 32'(req_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, bad=%0d", n_bad);
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat, nwr, nrdy, w0, rv_cnt;

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
        req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_mem_rw", 32'(mem_rw), 32'd0);
        rst = 1'b0;
        #1;
        check("idle_ready", 32'(req_ready), 32'd1);
        check("idle_mem_addr", mem_addr, 32'd0);
        check("idle_mem_wdata", mem_wdata, 32'd0);
        check("idle_rdata", resp_rdata, 32'd0);
        check("idle_err", 32'(resp_err), 32'd0);
        check("sel_in", 32'(mem_data_in_sel), 32'd0);
        check("sel_out", 32'(mem_data_out_sel), 32'd0);
        @(negedge clk);

        preload(5, 32'h8899AABB);
        preload(8, 32'h0);

        xact(1'b0, F3_B, 32'h16, 32'h0, rd, er, lat, nwr, nrdy);
        check("lb_data", rd, 32'hFFFFFF99);
        check("lb_err", 32'(er), 32'd0);
        check("lb_lat", 32'(lat), 32'd2);
        check("lb_nwr", 32'(nwr), 32'd0);
        check("lb_busy_ready", 32'(nrdy), 32'd0);

        xact(1'b0, F3_BU, 32'h16, 32'h0, rd, er, lat, nwr, nrdy);
        check("lbu_data", rd, 32'h00000099);
        check("lbu_lat", 32'(lat), 32'd2);

        w0 = wr_cnt;
        xact(1'b1, F3_B, 32'h15, 32'h12345677, rd, er, lat, nwr, nrdy);
        check("sb_lat", 32'(lat), 32'd3);
        check("sb_nwr", 32'(nwr), 32'd1);
        check("sb_wr_cnt", 32'(wr_cnt - w0), 32'd1);
        check("sb_err", 32'(er), 32'd0);
        check("sb_rdata", rd, 32'd0);
        check("sb_mem", mem[5], 32'h889977BB);
        check("sb_busy_ready", 32'(nrdy), 32'd0);

        preload(5, 32'h8899AABB);
        xact(1'b1, F3_H, 32'h16, 32'h0000CAFE, rd, er, lat, nwr, nrdy);
        check("sh_lat", 32'(lat), 32'd3);
        check("sh_nwr", 32'(nwr), 32'd1);
        check("sh_mem", mem[5], 32'hCAFEAABB);

        xact(1'b0, F3_H, 32'h16, 32'h0, rd, er, lat, nwr, nrdy);
        check("lh_data", rd, 32'hFFFFCAFE);
        xact(1'b0, F3_HU, 32'h16, 32'h0, rd, er, lat, nwr, nrdy);
        check("lhu_data", rd, 32'h0000CAFE);
        xact(1'b0, F3_B, 32'h14, 32'h0, rd, er, lat, nwr, nrdy);
        check("lb_lane0", rd, 32'hFFFFFFBB);
        xact(1'b0, F3_W, 32'h14, 32'h0, rd, er, lat, nwr, nrdy);
        check("lw_data", rd, 32'hCAFEAABB);

        xact(1'b0, F3_W, 32'h13, 32'h0, rd, er, lat, nwr, nrdy);
        check("lw_mis_err", 32'(er), 32'd1);
        check("lw_mis_rdata", rd, 32'd0);
        check("lw_mis_lat", 32'(lat), 32'd1);
        check("lw_mis_nwr", 32'(nwr), 32'd0);

        xact(1'b1, F3_W, 32'h0100_0000, 32'h55555555, rd, er, lat, nwr, nrdy);
        check("sw_oor_err", 32'(er), 32'd1);
        check("sw_oor_lat", 32'(lat), 32'd1);
        check("sw_oor_nwr", 32'(nwr), 32'd0);

        xact(1'b0, 3'b011, 32'h14, 32'h0, rd, er, lat, nwr, nrdy);
        check("ld_f3_err", 32'(er), 32'd1);
        check("ld_f3_rdata", rd, 32'd0);

        xact(1'b1, 3'b100, 32'h14, 32'h11111111, rd, er, lat, nwr, nrdy);
        check("st_f3_err", 32'(er), 32'd1);
        check("st_f3_nwr", 32'(nwr), 32'd0);
        check("st_f3_mem", mem[5], 32'hCAFEAABB);

        xact(1'b0, F3_H, 32'h15, 32'h0, rd, er, lat, nwr, nrdy);
        check("lh_mis_err", 32'(er), 32'd1);

        xact(1'b1, F3_W, 32'h20, 32'hDEADBEEF, rd, er, lat, nwr, nrdy);
        check("sw_lat", 32'(lat), 32'd2);
        check("sw_nwr", 32'(nwr), 32'd1);
        check("sw_err", 32'(er), 32'd0);
        xact(1'b0, F3_W, 32'h20, 32'h0, rd, er, lat, nwr, nrdy);
        check("b2b_lw_data", rd, 32'hDEADBEEF);
        check("b2b_lw_lat", 32'(lat), 32'd2);
        check("sw_mem", mem[8], 32'hDEADBEEF);

        // Reset lands while an SB sits in READ.
        preload(5, 32'h8899AABB);
        w0 = wr_cnt;
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_B;
        req_addr = 32'h15; req_wdata = 32'h12345677;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("rstmid_read_rw", 32'(mem_rw), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_ready", 32'(req_ready), 32'd0);
        check("rstmid_resp", 32'(resp_valid), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", 32'(req_ready), 32'd1);
        check("post_rst_rdata", resp_rdata, 32'd0);
        check("post_rst_err", 32'(resp_err), 32'd0);
        check("post_rst_rw", 32'(mem_rw), 32'd0);
        check("post_rst_addr", mem_addr, 32'd0);
        check("post_rst_wdata", mem_wdata, 32'd0);
        rv_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (resp_valid) rv_cnt++;
        end
        check("rstmid_no_resp", 32'(rv_cnt), 32'd0);
        check("rstmid_no_write", 32'(wr_cnt - w0), 32'd0);
        check("rstmid_mem", mem[5], 32'h8899AABB);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Load/store unit: the initiator for the data memory port (MemRW / Addr / DataW / DataR, size selects).
- Takes one RV32I load or store per handshake from the core, drives the word-indexed data memory, and returns a response.
- Owns byte-lane extraction and sign/zero extension for loads.
- Does read-modify-write for SB/SH, so sub-word stores never overwrite neighbouring bytes.
- Detects misaligned, out-of-range and illegal-funct3 accesses.

Parameters:
- DATA_SIZE, 32, data width.
- ADDRESS_SIZE, 32, byte-address width and width of mem_addr.
- WORD_ADDR_BITS, 18, number of word-index bits the memory decodes (depth 1<<18).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  LSU can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- req_addr  in  ADDRESS_SIZE  byte address.
- req_wdata  in  DATA_SIZE  store data.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  DATA_SIZE  load result; 0 for stores and errors.
- resp_err  out  1  access fault; valid with resp_valid.
- mem_rw  out  1  0 = read, 1 = write; memory writes on posedge clk when 1.
- mem_addr  out  ADDRESS_SIZE  word index.
- mem_data_in_sel  out  2  memory write size select; constant 2'b00 (full word).
- mem_data_out_sel  out  3  memory read size select; constant 3'b000 (full word).
- mem_wdata  out  DATA_SIZE  word to write.
- mem_rdata  in  DATA_SIZE  combinational read word, valid in the same cycle as mem_addr when mem_rw=0.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; resp_valid=0, resp_rdata=0, resp_err=0; mem_rw=0, mem_addr=0, mem_wdata=0; all request registers cleared. req_ready=0 while rst=1.
- req_ready = (state==IDLE) && !rst. The request is accepted on a posedge where req_valid && req_ready; all req_* fields are registered at that edge. req_* inputs are ignored outside IDLE.
- mem_addr = zero-extend(addr_q[WORD_ADDR_BITS+1:2]), held from accept until return to IDLE.
- Fault conditions, checked on the registered request:
  - illegal funct3: load funct3 not in {000,001,010,100,101}; store funct3 not in {000,001,010}.
  - misaligned: half with addr[0]!=0; word with addr[1:0]!=0.
  - out of range: addr[ADDRESS_SIZE-1:WORD_ADDR_BITS+2] != 0.
- States: IDLE, READ, WRITE, RESP.
  - IDLE: on accept -> RESP if faulted, else READ for loads and SB/SH, else WRITE for SW.
  - READ: mem_rw=0; mem_rdata is captured into rd_q at the end of the cycle. Next state: RESP for loads, WRITE for SB/SH.
  - WRITE: mem_rw=1; mem_wdata = SW ? wdata_q : merge(rd_q, wdata_q, addr_q[1:0], size). Next state RESP.
  - RESP: resp_valid=1 for exactly one cycle, then IDLE.
- Merge rules:
  - SB replaces byte lane addr[1:0] with wdata[7:0].
  - SH replaces lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
  - All other lanes keep rd_q.
- Load extract:
  - LB/LBU: byte lane addr[1:0], sign- / zero-extended.
  - LH/LHU: half at addr[1], sign- / zero-extended.
  - LW: the whole word.
- Latency, accept edge = T:
  - fault: resp at cycle T+1.
  - load or SW: resp at T+2.
  - SB/SH: resp at T+3.
- Faulted accesses never assert mem_rw and leave memory untouched. resp_err=1 and resp_rdata=0 on a fault.
- Back-to-back: the next request is accepted no earlier than the cycle after RESP, when the LSU is back in IDLE.
- Reset mid-operation: all state is aborted and no resp_valid is produced. If the reset edge is sampled while in WRITE, that edge's memory write still occurs, because mem_rw is decoded from the current state.
- mem_rw is never 1 outside WRITE. Between READ and WRITE the memory word can be modified by nothing else, since the LSU is the sole initiator.

Decomposition:
- Shared package rv_mem_pkg:
  - funct3 constants F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101.
  - MEM_READ=0, MEM_WRITE=1.
  - Size-select constants SEL_WORD_IN=2'b00, SEL_WORD_OUT=3'b000.
  - LSU state encoding.
- One natural sub-module, lsu_lane_unit (combinational): performs merge and extract from (word, wdata, offset, funct3). It is reused in both the READ and WRITE paths.

Test Plan:
- Memory word 5 = 32'h8899AABB. LB at addr 0x16 -> resp at T+2, rdata=32'hFFFFFF99, err=0. LBU at 0x16 -> 32'h00000099.
- SB, addr 0x15, wdata 32'h12345677 -> exactly one mem_rw=1 cycle at T+2; word 5 becomes 32'h8899_77BB; resp at T+3.
- SH, addr 0x16, wdata 32'h0000CAFE -> word 5 = 32'hCAFEAABB. Follow with LH at 0x16 -> 32'hFFFFCAFE.
- LW at 0x13 -> resp at T+1, err=1, rdata=0, mem_rw stays 0. SW at 0x0100_0000 (out of range) -> err=1. Load with funct3 3'b011 -> err=1.
- SW to 0x20 (wdata 32'hDEADBEEF) back-to-back with LW from 0x20 -> LW accepted the cycle after RESP, returns 32'hDEADBEEF. req_ready low throughout the busy states.
- rst asserted during the READ of an SB -> no resp_valid, no write to memory. After rst is released, req_ready=1 and all outputs are 0.
